// File: rtl/data_mem_responder_if.sv
// Request/response bus between a CPU data port and the memory responder.
// One outstanding transaction; valid/ready on both channels.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory with fixed accept-to-response latency,
// byte-lane stores and an out-of-range error flag.
module data_mem_responder #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 10
) (
  input logic clk,
  input logic reset,
  data_mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [2:0] CNT_INIT =
    (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_n;
  logic [2:0] cnt;

  logic              cap_we;
  logic              cap_err;
  logic [ADDR_W-1:0] cap_addr;
  logic [3:0]        cap_be;
  logic [31:0]       cap_wdata;

  logic              op_we;
  logic              op_err;
  logic [ADDR_W-1:0] op_addr;
  logic [3:0]        op_be;
  logic [31:0]       op_wdata;

  logic [31:0] mem [DEPTH];
  logic [31:0] wmerge;
  logic [31:0] rdata;
  logic        err;
  logic        in_err;
  logic        accept;
  logic        go_resp;
  logic        done;
  logic        wr_en;
  logic        unused_ok;

  assign unused_ok = ^bus.req_addr[1:0];
  assign in_err    = |bus.req_addr[31:ADDR_W+2];
  assign accept    = bus.req_valid && (state == IDLE);
  assign done      = (state == RESP) && bus.resp_ready;
  assign go_resp   = (accept && LATENCY == 1) ||
                     (state == BUSY && cnt == 3'd0);

  // With LATENCY=1 the access happens on the accept edge itself,
  // so the live request is used instead of the captured copy.
  always_comb begin
    if (state == IDLE) begin
      op_we    = bus.req_we;
      op_err   = in_err;
      op_addr  = bus.req_addr[ADDR_W+1:2];
      op_be    = bus.req_be;
      op_wdata = bus.req_wdata;
    end else begin
      op_we    = cap_we;
      op_err   = cap_err;
      op_addr  = cap_addr;
      op_be    = cap_be;
      op_wdata = cap_wdata;
    end
  end

  assign wr_en = go_resp && op_we && !op_err;

  always_comb begin
    wmerge = mem[op_addr];
    for (int b = 0; b < 4; b++) begin
      if (op_be[b]) wmerge[8*b +: 8] = op_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (cnt == 3'd0) state_n = RESP;
      RESP:    if (bus.resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    unique case (1'b1)
      state == IDLE: bus.req_ready  = 1'b1;
      state == RESP: bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 3'd0;
      cap_we    <= 1'b0;
      cap_err   <= 1'b0;
      cap_addr  <= '0;
      cap_be    <= 4'd0;
      cap_wdata <= 32'd0;
      rdata     <= 32'd0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        cap_we    <= bus.req_we;
        cap_err   <= in_err;
        cap_addr  <= bus.req_addr[ADDR_W+1:2];
        cap_be    <= bus.req_be;
        cap_wdata <= bus.req_wdata;
        cnt       <= CNT_INIT;
      end else if (state == BUSY && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (go_resp) begin
        err   <= op_err;
        rdata <= (op_err || op_we) ? 32'd0 : mem[op_addr];
      end else if (done) begin
        err   <= 1'b0;
        rdata <= 32'd0;
      end
    end
  end

  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    always_ff @(posedge clk or posedge reset) begin
      if (reset) mem[w] <= 32'd0;
      else if (wr_en && op_addr == ADDR_W'(w)) mem[w] <= wmerge;
    end
  end

  assign bus.resp_rdata = rdata;
  assign bus.resp_err   = err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY 1, 2 and 4.
// One shared stimulus set is steered to the selected instance.
module tb_data_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  int          sel;
  logic        req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  int          n_tests = 0;
  int          n_fail  = 0;

  data_mem_responder_if i1 ();
  data_mem_responder_if i2 ();
  data_mem_responder_if i4 ();

  data_mem_responder #(.LATENCY(1)) d1 (
    .clk(clk), .reset(rst[0]), .bus(i1.slave));
  data_mem_responder #(.LATENCY(2)) d2 (
    .clk(clk), .reset(rst[1]), .bus(i2.slave));
  data_mem_responder #(.LATENCY(4)) d4 (
    .clk(clk), .reset(rst[2]), .bus(i4.slave));

  assign i1.req_valid  = req_valid && (sel == 1);
  assign i2.req_valid  = req_valid && (sel == 2);
  assign i4.req_valid  = req_valid && (sel == 4);
  assign i1.resp_ready = resp_ready && (sel == 1);
  assign i2.resp_ready = resp_ready && (sel == 2);
  assign i4.resp_ready = resp_ready && (sel == 4);
  assign i1.req_we = req_we;
  assign i2.req_we = req_we;
  assign i4.req_we = req_we;
  assign i1.req_addr = req_addr;
  assign i2.req_addr = req_addr;
  assign i4.req_addr = req_addr;
  assign i1.req_be = req_be;
  assign i2.req_be = req_be;
  assign i4.req_be = req_be;
  assign i1.req_wdata = req_wdata;
  assign i2.req_wdata = req_wdata;
  assign i4.req_wdata = req_wdata;

  always_comb begin
    {req_ready, resp_valid, resp_err, resp_rdata} = '0;
    case (sel)
      1: {req_ready, resp_valid, resp_err, resp_rdata} =
           {i1.req_ready, i1.resp_valid, i1.resp_err, i1.resp_rdata};
      2: {req_ready, resp_valid, resp_err, resp_rdata} =
           {i2.req_ready, i2.resp_valid, i2.resp_err, i2.resp_rdata};
      4: {req_ready, resp_valid, resp_err, resp_rdata} =
           {i4.req_ready, i4.resp_valid, i4.resp_err, i4.resp_rdata};
      default: ;
    endcase
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(string tag, logic we, logic [31:0] addr,
                        logic [3:0] be, logic [31:0] wd, int lat,
                        logic [31:0] exp_rd, logic exp_err);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    check({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_be = be; req_wdata = wd;
    tick();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_be = '0; req_wdata = '0;
    n = 1;
    while (!resp_valid && n < 20) begin tick(); n++; end
    check({tag, "_lat"}, n, lat);
    check({tag, "_rd"}, resp_rdata, exp_rd);
    check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_clr"}, {29'd0, resp_valid, resp_err, req_ready},
          32'd1);
    check({tag, "_clrd"}, resp_rdata, 32'd0);
  endtask

  initial begin
    int acc;
    rst = 3'b111; sel = 2;
    req_valid = 0; req_we = 0; req_addr = 0; req_be = 0;
    req_wdata = 0; resp_ready = 0;
    #1;
    check("rst_state", {29'd0, resp_valid, resp_err, req_ready}, 32'd1);
    check("rst_rdata", resp_rdata, 32'd0);
    tick();
    rst = 3'b000;

    do_txn("st10", 1, 32'h10, 4'hF, 32'h1234_5678, 2, 0, 0);
    do_txn("ld10", 0, 32'h10, 4'h0, 0, 2, 32'h1234_5678, 0);
    do_txn("stpart", 1, 32'h10, 4'b0010, 32'h0000_AB00, 2, 0, 0);
    do_txn("ldpart", 0, 32'h10, 4'h0, 0, 2, 32'h1234_AB78, 0);
    do_txn("st_oor", 1, 32'h1000, 4'hF, 32'hFFFF_FFFF, 2, 0, 1);
    do_txn("ld0", 0, 32'h0, 4'h0, 0, 2, 32'h0, 0);
    do_txn("ld_oor", 0, 32'h8000_0010, 4'h0, 0, 2, 32'h0, 1);
    do_txn("st_be0", 1, 32'h10, 4'h0, 32'h0, 2, 0, 0);
    do_txn("ld_be0", 0, 32'h10, 4'h0, 0, 2, 32'h1234_AB78, 0);
    do_txn("st_top", 1, 32'hFFC, 4'hF, 32'hCAFE_F00D, 2, 0, 0);
    do_txn("ld_top", 0, 32'hFFF, 4'h0, 0, 2, 32'hCAFE_F00D, 0);

    req_valid = 1; req_we = 0; req_addr = 32'h10;
    tick();
    req_valid = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", {30'd0, resp_valid, req_ready}, 32'd2);
      check("bp_rd", resp_rdata, 32'h1234_AB78);
      req_valid = 1; req_we = 1; req_addr = 32'h10;
      req_be = 4'hF; req_wdata = 32'h0;
      tick();
      req_valid = 0; req_we = 0; req_be = 0;
    end
    check("bp_hold", {30'd0, resp_valid, req_ready}, 32'd2);
    resp_ready = 1;
    tick();
    resp_ready = 0;
    check("bp_rel", {30'd0, resp_valid, req_ready}, 32'd1);
    do_txn("ld_bp", 0, 32'h10, 4'h0, 0, 2, 32'h1234_AB78, 0);

    sel = 4;
    req_valid = 1; req_we = 1; req_addr = 32'h20;
    req_be = 4'hF; req_wdata = 32'hDEAD_BEEF;
    tick();
    req_valid = 0; req_we = 0; req_be = 0; req_wdata = 0;
    tick();
    tick();
    check("busy4", {30'd0, resp_valid, req_ready}, 32'd0);
    #1 rst[2] = 1'b1;
    #1;
    check("arst", {29'd0, resp_valid, resp_err, req_ready}, 32'd1);
    tick();
    rst[2] = 1'b0;
    do_txn("ld20", 0, 32'h20, 4'h0, 0, 4, 32'h0, 0);

    sel = 1;
    do_txn("st40", 1, 32'h40, 4'hF, 32'hA5A5_0001, 1, 0, 0);
    req_valid = 1; req_we = 0; req_addr = 32'h40; resp_ready = 1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("b2b_vld", {31'd0, resp_valid}, (i % 2 == 0) ? 1 : 0);
      if (resp_valid) begin
        acc++;
        check("b2b_rd", resp_rdata, 32'hA5A5_0001);
      end
    end
    req_valid = 0;
    tick();
    resp_ready = 0;
    check("b2b_cnt", acc, 4);
    check("b2b_idle", {30'd0, resp_valid, req_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter LATENCY, default 2, accept-to-response delay in cycles; legal range 1..7.
REQ-002 Parameter ADDR_W, default 10, word-address width; depth 2^ADDR_W words of 32 bits.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  CPU presents a memory request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address; bits [1:0] ignored.
REQ-009 req_be  input  4  byte enables for stores, bit i = byte lane i (bits [8i+7:8i]).
REQ-010 req_wdata  input  32  store data, lane-aligned.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  CPU accepts response.
REQ-013 resp_rdata  output  32  full word read (loads); 0 for stores.
REQ-014 resp_err  output  1  address out of range for this request.

Function
REQ-015 FSM states IDLE, BUSY, RESP; one outstanding transaction at most.
REQ-016 req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-017 Accept = req_valid & req_ready at a rising edge; req_we, word address, req_be, req_wdata captured at that edge; inputs ignored afterwards until IDLE.
REQ-018 On accept: LATENCY=1 -> RESP next cycle; else BUSY with down-counter loaded LATENCY-2, BUSY -> RESP when counter is 0 at an edge.
REQ-019 resp_valid SHALL first assert exactly LATENCY cycles after the accept edge.
REQ-020 Range check: req_addr[31:ADDR_W+2] nonzero -> resp_err=1, memory untouched, resp_rdata=0.
REQ-021 In-range store: lanes with be=1 written at the edge entering RESP; lanes with be=0 unchanged; be=0000 writes nothing, no error.
REQ-022 In-range load: resp_rdata = memory word at that edge including any earlier store; no sign/zero extension (CPU side does it).
REQ-023 resp_rdata and resp_err SHALL be stable while resp_valid=1.
REQ-024 RESP -> IDLE on edge with resp_ready=1; resp_valid, resp_rdata, resp_err drop to 0 on entering IDLE.
REQ-025 resp_ready=1 outside RESP has no effect; req_valid outside IDLE has no effect.
REQ-026 New request accepted no earlier than the cycle after RESP -> IDLE (minimum transaction period LATENCY+1 cycles).

Reset
REQ-027 reset=1 SHALL immediately force IDLE, counter 0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, all memory words 0.
REQ-028 reset asserted in BUSY SHALL drop the transaction with no memory write; reset in RESP discards the pending response.
REQ-029 First accept possible on first rising edge with reset=0.

Verification
REQ-030 LATENCY=2: store addr 0x0000_0010, be=1111, wdata 0x1234_5678; then load 0x10 -> resp_valid 2 cycles after each accept, load rdata 0x1234_5678, resp_err 0.
REQ-031 Partial store: word 0x10 = 0x1234_5678, store be=0010, wdata 0x0000_AB00 -> load returns 0x1234_AB78.
REQ-032 Out of range (ADDR_W=10): store 0x0000_1000, wdata 0xFFFF_FFFF -> resp_err 1; load 0x0000_0000 then still returns 0.
REQ-033 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid and rdata held, req_ready 0, req_valid pulses ignored; resp_ready=1 -> IDLE next edge.
REQ-034 Reset mid-BUSY (LATENCY=4, store 0x20 in flight, reset 2 cycles after accept) -> outputs cleared asynchronously, later load 0x20 returns 0.
REQ-035 LATENCY=1 back-to-back loads with resp_ready tied 1 -> accepts every 2nd cycle, resp_valid 1 cycle after each accept.
